cic_comp_fir: RTL and testbench

- Sequential CIC droop-compensation FIR. Sits directly downstream of the CIC decimator in the sensor readout chain.
- Consumes one decimated CIC output word per strobe and computes a symmetric-coefficient FIR using a single shared multiplier, one tap per cycle.
- Emits one compensated, scaled sample with a one-cycle valid pulse. Runs in the system clock domain, not the CIC's divided clock.

---
 rtl/cic_comp_fir_pkg.sv | 36 +++
 rtl/cic_comp_mac.sv | 41 ++++
 rtl/cic_comp_fir.sv | 144 ++++++++++++++
 tb/tb_cic_comp_fir.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cic_comp_fir_pkg.sv
// Shared definitions for the CIC compensation FIR: FSM state encodings,
// default coefficients and a constant clog2 helper.
`ifndef __CIC_COMP_FIR_DEFS_INCLUDE__
`define __CIC_COMP_FIR_DEFS_INCLUDE__

package cic_comp_fir_pkg;

  // FSM state encodings
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  // Default 7-tap droop-compensation coefficients (sum 1024 for unity DC gain)
  function automatic logic signed [15:0] def_coef(input int unsigned k);
    logic signed [15:0] c;
    case (k)
      0, 6:    c = -16'sd64;
      1, 5:    c = 16'sd128;
      2, 4:    c = -16'sd256;
      3:       c = 16'sd1408;
      default: c = 16'sd0;
    endcase
    return c;
  endfunction

  // Ceiling log2 for elaboration-time widths
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

`endif

// File: rtl/cic_comp_mac.sv
// Signed multiply-accumulate with synchronous clear and enable.
// Clear has priority over enable; the accumulator is sign-extended from the product.
module cic_comp_mac #(
  parameter int unsigned A_WIDTH   = 12,
  parameter int unsigned B_WIDTH   = 16,
  parameter int unsigned ACC_WIDTH = 31
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_clr,
  input  logic                        i_en,
  input  logic signed [A_WIDTH-1:0]   i_a,
  input  logic signed [B_WIDTH-1:0]   i_b,
  output logic signed [ACC_WIDTH-1:0] o_acc
);

  localparam int unsigned PW = A_WIDTH + B_WIDTH;

  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;

  // Next accumulator value: clear, accumulate or hold
  always_comb begin
    prod  = i_a * i_b;
    acc_d = acc_q;
    if (i_clr) begin
      acc_d = '0;
    end else if (i_en) begin
      acc_d = acc_q + {{(ACC_WIDTH - PW){prod[PW-1]}}, prod};
    end
  end

  // Accumulator register
  always_ff @(posedge i_clk) begin
    if (i_rst) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign o_acc = acc_q;

endmodule

// File: rtl/cic_comp_fir.sv
// Sequential CIC droop-compensation FIR: one shared multiplier, one tap per cycle.
// Optional build macro CIC_COMP_FIR_SAT_EN: saturate the scaled result to O_WIDTH
// instead of keeping the low bits (wrap).
module cic_comp_fir
  import cic_comp_fir_pkg::*;
#(
  parameter int unsigned I_WIDTH    = 16,
  parameter int unsigned O_WIDTH    = 16,
  parameter int unsigned TAPS       = 7,
  parameter int unsigned COEF_WIDTH = 12,
  parameter int unsigned SHIFT      = 10
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic                      i_valid,
  input  logic signed [I_WIDTH-1:0] i_data,
  output logic signed [O_WIDTH-1:0] o_data,
  output logic                      o_valid,
  output logic                      o_busy,
  output logic                      o_overrun
);

  localparam int unsigned PtrW = clog2(TAPS);
  localparam int unsigned AccW = I_WIDTH + COEF_WIDTH + clog2(TAPS);

  localparam logic signed [AccW-1:0] OMax = {{(AccW - O_WIDTH + 1){1'b0}}, {(O_WIDTH - 1){1'b1}}};
  localparam logic signed [AccW-1:0] OMin = {{(AccW - O_WIDTH + 1){1'b1}}, {(O_WIDTH - 1){1'b0}}};

  logic [1:0]                state_q, state_d;
  logic [PtrW-1:0]           wptr_q, wptr_d;
  logic [PtrW-1:0]           tap_q, tap_d;
  logic signed [I_WIDTH-1:0] dline_q [TAPS];
  logic signed [O_WIDTH-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      overrun_q, overrun_d;

  logic                         wr_en, mac_clr, mac_en;
  int unsigned                  rd_sum;
  logic [PtrW-1:0]              rd_idx;
  logic signed [COEF_WIDTH-1:0] coef;
  logic signed [AccW-1:0]       mac_acc, shifted;
  logic signed [O_WIDTH-1:0]    result;

  // Operand select: tap k reads the sample written k strobes ago
  always_comb begin
    rd_sum = 32'(wptr_q) + TAPS - 32'(tap_q) - 1;
    rd_idx = PtrW'(rd_sum % TAPS);
    coef   = COEF_WIDTH'(def_coef(32'(tap_q)));
  end

  cic_comp_mac #(
    .A_WIDTH  (COEF_WIDTH),
    .B_WIDTH  (I_WIDTH),
    .ACC_WIDTH(AccW)
  ) u_mac (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_clr(mac_clr),
    .i_en (mac_en),
    .i_a  (coef),
    .i_b  (dline_q[rd_idx]),
    .o_acc(mac_acc)
  );

  // Scale the accumulator (floor shift) and reduce to the output width
  always_comb begin
    shifted = mac_acc >>> SHIFT;
`ifdef CIC_COMP_FIR_SAT_EN
    if (shifted > OMax)      result = O_WIDTH'(OMax);
    else if (shifted < OMin) result = O_WIDTH'(OMin);
    else                     result = O_WIDTH'(shifted);
`else
    result = O_WIDTH'(shifted);
`endif
  end

  // FSM next state; nothing advances while i_en is low
  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    tap_d     = tap_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    wr_en     = 1'b0;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    if (i_en) begin
      valid_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            wr_en   = 1'b1;
            wptr_d  = (wptr_q == PtrW'(TAPS - 1)) ? '0 : wptr_q + 1'b1;
            mac_clr = 1'b1;
            tap_d   = '0;
            state_d = MAC;
          end
        end
        MAC: begin
          mac_en = 1'b1;
          if (tap_q == PtrW'(TAPS - 1)) state_d = OUT;
          else                          tap_d   = tap_q + 1'b1;
        end
        OUT: begin
          data_d  = result;
          valid_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      // A strobe outside IDLE is dropped and flagged
      if (i_valid && (state_q != IDLE)) overrun_d = 1'b1;
    end
  end

  // State registers and delay line
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      tap_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < TAPS; i++) dline_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      tap_q     <= tap_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      if (wr_en) dline_q[wptr_q] <= i_data;
    end
  end

  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_busy    = (state_q != IDLE);
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Randomized self-checking bench for cic_comp_fir against a convolution model.
module tb_cic_comp_fir;

  logic               clk = 1'b0;
  logic               i_rst, i_en, i_valid;
  logic signed [15:0] i_data;
  logic signed [15:0] o_data;
  logic               o_valid, o_busy, o_overrun;

  always #5 clk = ~clk;

  cic_comp_fir dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_en     (i_en),
    .i_valid  (i_valid),
    .i_data   (i_data),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_busy   (o_busy),
    .o_overrun(o_overrun)
  );

  int     n_checks = 0;
  int     n_bad = 0;
  int     h[7] = '{-64, 128, -256, 1408, -256, 128, -64};
  int     imp_tab[8] = '{-63, 125, -250, 1375, -250, 125, -63, 0};
  longint hist[7];

  task automatic check_val(input string tag, input logic signed [63:0] obs,
                           input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: history of accepted samples, newest first
  function automatic void model_reset();
    for (int i = 0; i < 7; i++) hist[i] = 0;
  endfunction

  function automatic void model_push(input longint d);
    for (int i = 6; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = d;
  endfunction

  function automatic longint model_out();
    longint s, q;
    s = 0;
    for (int i = 0; i < 7; i++) s += h[i] * hist[i];
    q = s / 1024;
    if ((s % 1024) != 0 && s < 0) q--;
`ifdef CIC_COMP_FIR_SAT_EN
    if (q > 32767) q = 32767;
    else if (q < -32768) q = -32768;
`else
    q = longint'(shortint'(q));
`endif
    return q;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic signed [15:0] d);
    i_valid = 1'b1;
    i_data  = d;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic await_out(input int budget, output int n, output logic got);
    n   = 0;
    got = 1'b0;
    while (n < budget && !got) begin
      tick();
      n++;
      if (o_valid) got = 1'b1;
    end
  endtask

  task automatic xact(input string tag, input logic signed [15:0] d, input int spacing,
                      output longint v);
    int     n;
    logic   got;
    longint exp;
    model_push(d);
    exp = model_out();
    pulse(d);
    check_val({tag, " busy"}, o_busy, 1);
    await_out(40, n, got);
    check_val({tag, " latency"}, n, 8);
    check_val({tag, " data"}, o_data, exp);
    v = o_data;
    for (int i = n + 1; i < spacing; i++) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint             v, exp;
    int                 n;
    logic               got;
    logic signed [15:0] d;

    i_rst = 1'b1; i_en = 1'b1; i_valid = 1'b0; i_data = '0;
    model_reset();
    repeat (3) tick();
    i_rst = 1'b0;
    check_val("rst data", o_data, 0);
    check_val("rst valid", o_valid, 0);
    check_val("rst busy", o_busy, 0);
    check_val("rst overrun", o_overrun, 0);

    for (int i = 0; i < 8; i++) begin
      xact("impulse", (i == 0) ? 16'sd1000 : 16'sd0, 32, v);
      check_val("impulse table", v, imp_tab[i]);
    end

    for (int i = 0; i < 10; i++) begin
      xact("dc", 16'sd1000, 12, v);
      if (i >= 6) check_val("dc settled", v, 1000);
    end

    for (int i = 0; i < 10; i++) xact("sat", (i % 2 == 0) ? 16'sd32767 : -16'sd32767, 10, v);

    for (int i = 0; i < 20; i++) begin
      d = 16'($urandom);
      xact("random", d, int'($urandom_range(9, 14)), v);
    end

    // Second strobe 3 cycles into MAC is dropped
    check_val("ovr before", o_overrun, 0);
    model_push(1234);
    exp = model_out();
    pulse(16'sd1234);
    tick(); tick();
    pulse(-16'sd5000);
    await_out(40, n, got);
    check_val("ovr latency", n, 5);
    check_val("ovr data", o_data, exp);
    check_val("ovr flag", o_overrun, 1);
    repeat (4) tick();
    xact("ovr next", 16'sd700, 12, v);

    // Clock enable low for 5 cycles mid-MAC
    model_push(-3000);
    exp = model_out();
    pulse(-16'sd3000);
    tick(); tick();
    i_en = 1'b0;
    repeat (5) tick();
    check_val("freeze busy", o_busy, 1);
    i_en = 1'b1;
    await_out(40, n, got);
    check_val("freeze latency", n, 6);
    check_val("freeze data", o_data, exp);
    repeat (3) tick();

    // Strobe while disabled is ignored
    i_en = 1'b0;
    pulse(16'sd9999);
    i_en = 1'b1;
    await_out(20, n, got);
    check_val("en low no valid", got, 0);
    xact("after en low", 16'sd321, 12, v);

    // Reset mid-MAC aborts and clears history
    pulse(16'sd4444);
    repeat (3) tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    model_reset();
    check_val("mid rst data", o_data, 0);
    check_val("mid rst valid", o_valid, 0);
    check_val("mid rst busy", o_busy, 0);
    check_val("mid rst overrun", o_overrun, 0);
    await_out(20, n, got);
    check_val("mid rst no valid", got, 0);
    for (int i = 0; i < 8; i++) begin
      xact("impulse2", (i == 0) ? 16'sd1000 : 16'sd0, 32, v);
      check_val("impulse2 table", v, imp_tab[i]);
    end

    // Strobe coinciding with OUT is an overrun; strobe one cycle later is accepted
    check_val("out ovr before", o_overrun, 0);
    model_push(2500);
    exp = model_out();
    pulse(16'sd2500);
    repeat (7) tick();
    pulse(16'sd8888);
    check_val("out valid", o_valid, 1);
    check_val("out data", o_data, exp);
    check_val("out ovr flag", o_overrun, 1);
    xact("after out", -16'sd1500, 12, v);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
